// File: rtl/mc_control_unit.sv
// rtl/mc_control_unit.sv - multicycle main controller for the tinyCPU core
module mc_control_unit #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       alu_zero,
    input  logic       mem_ready,
    output logic [3:0] alu_op,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_source,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       illegal,
    output logic       mem_timeout,
    output logic [3:0] state_dbg
);
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_FETCH     = 4'd1;
    localparam logic [3:0] S_DECODE    = 4'd2;
    localparam logic [3:0] S_EXECUTE   = 4'd3;
    localparam logic [3:0] S_R_WB      = 4'd4;
    localparam logic [3:0] S_ADDR_CALC = 4'd5;
    localparam logic [3:0] S_MEM_READ  = 4'd6;
    localparam logic [3:0] S_MEM_WB    = 4'd7;
    localparam logic [3:0] S_MEM_WRITE = 4'd8;
    localparam logic [3:0] S_I_WB      = 4'd9;
    localparam logic [3:0] S_BRANCH    = 4'd10;
    localparam logic [3:0] S_BR_DONE   = 4'd11;
    localparam logic [3:0] S_JUMP      = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    logic [3:0]    state_q, state_d;
    logic [CW-1:0] wait_q, wait_d;
    logic          waiting;

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        waiting     = 1'b0;
        alu_op      = ALU_ADD;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        iord        = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_source   = 2'b00;
        reg_write   = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        illegal     = 1'b0;
        mem_timeout = 1'b0;

        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                waiting   = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                pc_write = 1'b1;
                case (opcode)
                    OP_RTYPE:              state_d = S_EXECUTE;
                    OP_LW, OP_SW, OP_ADDI: state_d = S_ADDR_CALC;
                    OP_BEQ:                state_d = S_BRANCH;
                    OP_J:                  state_d = S_JUMP;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                state_d   = S_R_WB;
                case (funct)
                    6'b100000: alu_op = ALU_ADD;
                    6'b100010: alu_op = ALU_SUB;
                    6'b100100: alu_op = ALU_AND;
                    6'b100101: alu_op = ALU_OR;
                    6'b101010: alu_op = ALU_SLT;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = S_FETCH;
            end
            S_ADDR_CALC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                case (opcode)
                    OP_LW:   state_d = S_MEM_READ;
                    OP_SW:   state_d = S_MEM_WRITE;
                    OP_ADDI: state_d = S_I_WB;
                    default: state_d = S_FETCH;
                endcase
            end
            // Address/result stays in the ALU output register only while its inputs are held
            S_MEM_READ: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                mem_read  = 1'b1;
                iord      = 1'b1;
                waiting   = 1'b1;
                if (mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WRITE: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                mem_write = 1'b1;
                iord      = 1'b1;
                waiting   = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_I_WB: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                state_d   = S_BR_DONE;
            end
            S_BR_DONE: begin
                pc_write  = alu_zero;
                pc_source = 2'b01;
                state_d   = S_FETCH;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
                state_d   = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase

        if (waiting && !mem_ready && wait_q == WAIT_LAST) begin
            mem_timeout = 1'b1;
            state_d     = S_FETCH;
        end

        // A timed-out FETCH re-enters FETCH, so the counter must clear on abort too
        if (state_d != state_q || mem_timeout) begin
            wait_d = '0;
        end else if (waiting && !mem_ready) begin
            wait_d = wait_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    assign state_dbg = state_q;
endmodule

// File: tb/tb_mc_control_unit.sv
// tb/tb_mc_control_unit.sv - table-driven bench for mc_control_unit
module tb_mc_control_unit;
    localparam logic [3:0] IDLE = 4'd0, FETCH = 4'd1, DECODE = 4'd2, EXEC = 4'd3;
    localparam logic [3:0] RWB = 4'd4, ADDR = 4'd5, MRD = 4'd6, MWB = 4'd7;
    localparam logic [3:0] MWR = 4'd8, IWB = 4'd9, BR = 4'd10, BRD = 4'd11, JMP = 4'd12;

    localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
    localparam logic [5:0] ADDI = 6'b001000, BEQ = 6'b000100, J = 6'b000010, BAD = 6'b111111;
    localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100;
    localparam logic [5:0] F_OR = 6'b100101, F_SLT = 6'b101010;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode, funct;
    logic       alu_zero, mem_ready;
    logic [3:0] alu_op, state_dbg;
    logic       alu_src_a, iord, mem_read, mem_write, ir_write, pc_write;
    logic [1:0] alu_src_b, pc_source;
    logic       reg_write, reg_dst, mem_to_reg, illegal, mem_timeout;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic        rdy;
        logic [22:0] exp;
    } vec_t;

    vec_t vecs[$];

    mc_control_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
        .alu_zero(alu_zero), .mem_ready(mem_ready), .alu_op(alu_op),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .pc_write(pc_write), .pc_source(pc_source), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .illegal(illegal),
        .mem_timeout(mem_timeout), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    wire [22:0] act = {state_dbg, alu_op, alu_src_a, alu_src_b, iord, mem_read, mem_write,
                       ir_write, pc_write, pc_source, reg_write, reg_dst, mem_to_reg,
                       illegal, mem_timeout};

    task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, a, e);
        end
    endtask

    task automatic add(input logic [5:0] op, input logic [5:0] fn, input logic z, input logic rdy,
                       input logic [3:0] st, input logic [3:0] aop, input logic sa,
                       input logic [1:0] sb, input logic io, input logic mr, input logic mw,
                       input logic irw, input logic pcw, input logic [1:0] pcs, input logic rw,
                       input logic rd, input logic m2r, input logic ill, input logic tmo);
        vec_t v;
        v.op  = op;
        v.fn  = fn;
        v.z   = z;
        v.rdy = rdy;
        v.exp = {st, aop, sa, sb, io, mr, mw, irw, pcw, pcs, rw, rd, m2r, ill, tmo};
        vecs.push_back(v);
    endtask

    task automatic fetch_v(input logic [5:0] op, input logic [5:0] fn, input logic rdy);
        add(op, fn, 0, rdy, FETCH, 4'b0010, 0, 2'b01, 0, 1, 0, rdy, 0, 2'b00, 0, 0, 0, 0, 0);
    endtask

    task automatic decode_v(input logic [5:0] op, input logic [5:0] fn, input logic ill);
        add(op, fn, 0, 1, DECODE, 4'b0010, 0, 2'b00, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0, ill, 0);
    endtask

    task automatic rtype_v(input logic [5:0] fn, input logic [3:0] aop);
        fetch_v(R, fn, 1);
        decode_v(R, fn, 0);
        add(R, fn, 0, 1, EXEC, aop, 1, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        add(R, fn, 0, 1, RWB, 4'b0010, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 1, 1, 0, 0, 0);
    endtask

    task automatic mem_v(input logic [5:0] op, input logic [3:0] st, input logic rdy, input logic tmo);
        add(op, 0, 0, rdy, st, 4'b0010, 1, 2'b10, 1, st == MRD, st == MWR, 0, 0, 2'b00, 0, 0, 0, 0, tmo);
    endtask

    task automatic addr_v(input logic [5:0] op);
        fetch_v(op, 0, 1);
        decode_v(op, 0, 0);
        add(op, 0, 0, 1, ADDR, 4'b0010, 1, 2'b10, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    endtask

    task automatic beq_v(input logic z);
        fetch_v(BEQ, 0, 1);
        decode_v(BEQ, 0, 0);
        add(BEQ, 0, 0, 1, BR, 4'b0110, 1, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        add(BEQ, 0, z, 1, BRD, 4'b0010, 0, 2'b00, 0, 0, 0, 0, z, 2'b01, 0, 0, 0, 0, 0);
    endtask

    initial begin
        add(R, F_SUB, 0, 1, IDLE, 4'b0010, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        rtype_v(F_SUB, 4'b0110);
        fetch_v(R, F_ADD, 0);
        fetch_v(R, F_ADD, 0);
        rtype_v(F_ADD, 4'b0010);
        rtype_v(F_AND, 4'b0000);
        rtype_v(F_OR, 4'b0001);
        rtype_v(F_SLT, 4'b0111);
        // lw with three wait cycles: ready arrives on the last counted cycle
        addr_v(LW);
        repeat (3) mem_v(LW, MRD, 0, 0);
        mem_v(LW, MRD, 1, 0);
        add(LW, 0, 0, 1, MWB, 4'b0010, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 1, 0, 1, 0, 0);
        addr_v(ADDI);
        add(ADDI, 0, 0, 1, IWB, 4'b0010, 1, 2'b10, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0, 0, 0);
        beq_v(1);
        beq_v(0);
        fetch_v(J, 0, 1);
        decode_v(J, 0, 0);
        add(J, 0, 0, 1, JMP, 4'b0010, 0, 2'b00, 0, 0, 0, 0, 1, 2'b10, 0, 0, 0, 0, 0);
        fetch_v(BAD, 0, 1);
        decode_v(BAD, 0, 1);
        fetch_v(R, 6'b000000, 1);
        decode_v(R, 6'b000000, 0);
        add(R, 6'b000000, 0, 1, EXEC, 4'b0010, 1, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 0);
        addr_v(SW);
        repeat (3) mem_v(SW, MWR, 0, 0);
        mem_v(SW, MWR, 1, 0);
        addr_v(SW);
        repeat (3) mem_v(SW, MWR, 0, 0);
        mem_v(SW, MWR, 0, 1);
        fetch_v(R, 0, 0);

        rst_n = 1'b0;
        opcode = '0;
        funct = '0;
        alu_zero = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("reset_state", act, {IDLE, 4'b0010, 15'b0});
        #1 rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            opcode    = vecs[i].op;
            funct     = vecs[i].fn;
            alu_zero  = vecs[i].z;
            mem_ready = vecs[i].rdy;
            #1;
            check($sformatf("vec%0d", i), act, vecs[i].exp);
            check($sformatf("vec%0d_mem_excl", i), mem_read & mem_write, 0);
            check($sformatf("vec%0d_wr_excl", i), reg_write & pc_write, 0);
            @(negedge clk);
        end

        // sw interrupted by reset while the write request is outstanding
        opcode = SW;
        mem_ready = 1'b1;
        #1 check("rst_seq_fetch", state_dbg, FETCH);
        @(negedge clk);
        #1 check("rst_seq_decode", state_dbg, DECODE);
        @(negedge clk);
        #1 check("rst_seq_addr", state_dbg, ADDR);
        @(negedge clk);
        mem_ready = 1'b0;
        #1 check("rst_seq_mem_write_on", mem_write, 1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_async_mem_write", mem_write, 0);
        check("rst_async_state", state_dbg, IDLE);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("rst_release_idle", state_dbg, IDLE);
        @(negedge clk);
        #1;
        check("rst_release_fetch", state_dbg, FETCH);
        check("rst_release_mem_read", mem_read, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
